ahb_slave_mem: RTL

- AHB-Lite responder: a word-addressed on-chip memory target for the team's AHB master, giving the master bench a checkable far end.
- Decodes its own address window and applies programmable wait states.
- Returns two-cycle ERROR responses for illegal accesses.
- Sits on the AHB side in place of the bridge during master-only regressions; the bench ties Hreadyin to Hreadyout (single-slave bus).

---
 rtl/ahb_slave_mem_if.sv | 21 ++
 rtl/ahb_slave_mem.sv | 87 ++++++++
 2 files changed

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus signals between a master and the memory responder
interface ahb_slave_mem_if;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    modport master (
        output Hreadyin, Htrans, Hwrite, Haddr, Hwdata,
        input  Hreadyout, Hrdata, Hresp
    );

    modport slave (
        input  Hreadyin, Htrans, Hwrite, Haddr, Hwdata,
        output Hreadyout, Hrdata, Hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory responder with wait states and two-cycle ERROR responses
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1
) (
    input logic            Hclk,
    input logic            Hresetn,
    ahb_slave_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic          open, accept, legal;

    // A new address phase can only be taken in cycles that present Hreadyout=1
    assign open   = (state == IDLE) || (state == DATA) || (state == ERR2);
    assign accept = open && bus.Hreadyin && bus.Htrans[1];
    assign offset = bus.Haddr - BASE_ADDR;
    assign legal  = (bus.Haddr[1:0] == 2'b00) && (bus.Haddr >= BASE_ADDR) && (offset < 32'(DEPTH * 4));

    // State and wait-counter register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture direction and word index of each accepted transfer
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wr_q  <= 1'b0;
            idx_q <= '0;
        end else if (accept) begin
            wr_q  <= bus.Hwrite;
            idx_q <= bus.Haddr[AW+1:2];
        end
    end

    // Memory: cleared by reset, written on the edge that ends a write DATA cycle
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == DATA && wr_q) begin
            mem[idx_q] <= bus.Hwdata;
        end
    end

    // Next state, wait counter and response outputs
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus.Hreadyout = 1'b1;
        bus.Hresp     = 2'b00;
        bus.Hrdata    = '0;
        case (state)
            WAIT: begin
                bus.Hreadyout = 1'b0;
                if (cnt == 3'd0) state_nxt = DATA;
                else cnt_nxt = cnt - 3'd1;
            end
            ERR1: begin
                bus.Hreadyout = 1'b0;
                bus.Hresp     = 2'b01;
                state_nxt     = ERR2;
            end
            default: begin
                if (state == ERR2) bus.Hresp = 2'b01;
                if (state == DATA && !wr_q) bus.Hrdata = mem[idx_q];
                state_nxt = !accept ? IDLE : !legal ? ERR1 : (WAIT_STATES > 0) ? WAIT : DATA;
                if (accept) cnt_nxt = WS_LOAD;
            end
        endcase
    end
endmodule
